// File: rtl/uart_rx_bit_timer.sv
// UART receive bit-timing engine: start detection and validation, mid-bit data strobes, stop-bit check.
// Define UART_RX_PARITY_EN to insert a parity bit slot; this adds the parity_slot output.
module uart_rx_bit_timer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          count_ENABLE,
  input  logic                          sample_ENABLE,
  input  logic                          rx_line,
  output logic [$clog2(OVERSAMPLE)-1:0] sample_counter,
  output logic [$clog2(DATA_BITS)-1:0]  bit_index,
  output logic                          sample_strobe,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          start_error,
  output logic                          stop_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_slot
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t state;
  logic   at_mid;
  logic   at_wrap;

  assign at_mid  = (sample_counter == MID);
  assign at_wrap = (sample_counter == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      sample_counter <= '0;
      bit_index      <= '0;
      sample_strobe  <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      start_error    <= 1'b0;
      stop_error     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_slot    <= 1'b0;
`endif
    end else begin
      sample_strobe <= 1'b0;
      frame_done    <= 1'b0;
      start_error   <= 1'b0;
      stop_error    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_slot   <= 1'b0;
`endif
      if (!count_ENABLE) begin
        state          <= IDLE;
        sample_counter <= '0;
        bit_index      <= '0;
        busy           <= 1'b0;
      end else if (sample_ENABLE) begin
        if (state == IDLE) begin
          // The detecting tick counts as tick 0 of the start bit.
          if (!rx_line) begin
            state          <= START;
            sample_counter <= CW'(1);
            bit_index      <= '0;
            busy           <= 1'b1;
          end
        end else begin
          sample_counter <= at_wrap ? '0 : sample_counter + 1'b1;
          case (state)
            START: begin
              if (at_mid && rx_line) begin
                start_error    <= 1'b1;
                state          <= IDLE;
                sample_counter <= '0;
                busy           <= 1'b0;
              end else if (at_wrap) begin
                state     <= DATA;
                bit_index <= '0;
              end
            end
            DATA: begin
              if (at_mid) sample_strobe <= 1'b1;
              // bit_index stays on the last data bit once DATA is left.
              if (at_wrap) begin
                if (bit_index == LAST_BIT) state <= AFTER_DATA;
                else bit_index <= bit_index + 1'b1;
              end
            end
            PARITY: begin
              if (at_mid) begin
                sample_strobe <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_slot   <= 1'b1;
`endif
              end
              if (at_wrap) state <= STOP;
            end
            STOP: begin
              // Leave at mid-bit so a start edge in the stop bit's second half is caught.
              if (at_mid) begin
                frame_done     <= 1'b1;
                stop_error     <= ~rx_line;
                state          <= IDLE;
                sample_counter <= '0;
                busy           <= 1'b0;
              end
            end
            default: begin
              state          <= IDLE;
              sample_counter <= '0;
              busy           <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Self-checking bench for uart_rx_bit_timer: tick-position reference model plus directed frame scenarios.
module tb_uart_rx_bit_timer;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int LAST_PHASE = DB + 1 + PE;
  localparam int FD_TICK    = PE ? 168 : 152;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic count_ENABLE = 1'b1;
  logic sample_ENABLE = 1'b0;
  logic rx_line = 1'b1;
  logic [3:0] sample_counter;
  logic [2:0] bit_index;
  logic sample_strobe, busy, frame_done, start_error, stop_error;
  logic parity_w;

  uart_rx_bit_timer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .count_ENABLE  (count_ENABLE),
    .sample_ENABLE (sample_ENABLE),
    .rx_line       (rx_line),
    .sample_counter(sample_counter),
    .bit_index     (bit_index),
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .frame_done    (frame_done),
    .start_error   (start_error),
    .stop_error    (stop_error)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_slot   (parity_w)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign parity_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: position of the current tick relative to the detecting tick.
  bit m_active = 1'b0;
  int m_t = 0, m_bi = 0, ph = 0, nph = 0;
  int e_cnt = 0, e_busy = 0, e_strobe = 0, e_fd = 0, e_se = 0, e_ste = 0, e_par = 0;

  // Observed event history, written only by the compare process.
  int tick_no = 0, prev_cnt = 0;
  int strobe_cnt = 0, fd_cnt = 0, se_cnt = 0, ste_cnt = 0, par_cnt = 0, bad_mid = 0;
  int par_at = 0, par_rx = 0, last_fd_tick = 0, last_se_tick = 0, last_ste_tick = 0;
  logic [15:0] rx_bits = '0;

  initial begin
    forever begin
      @(posedge clk);
      e_strobe = 0; e_fd = 0; e_se = 0; e_ste = 0; e_par = 0;
      if (reset) begin
        m_active = 1'b0; m_bi = 0; e_cnt = 0; e_busy = 0;
      end else if (!count_ENABLE) begin
        m_active = 1'b0; m_bi = 0; e_cnt = 0; e_busy = 0;
      end else if (sample_ENABLE) begin
        if (!m_active) begin
          if (!rx_line) begin
            m_active = 1'b1; m_t = 0; m_bi = 0; e_cnt = 1; e_busy = 1;
          end
        end else begin
          m_t++;
          ph = m_t / OS;
          if (m_t % OS == OS / 2) begin
            if (ph == 0) begin
              if (rx_line) begin e_se = 1; m_active = 1'b0; end
            end else if (ph <= DB) begin
              e_strobe = 1;
            end else if (ph < LAST_PHASE) begin
              e_strobe = 1; e_par = 1;
            end else begin
              e_fd = 1; e_ste = rx_line ? 0 : 1; m_active = 1'b0;
            end
          end
          if (m_active) begin
            e_cnt = (m_t + 1) % OS;
            nph = (m_t + 1) / OS;
            m_bi = (nph < 1) ? 0 : ((nph - 1 > DB - 1) ? DB - 1 : nph - 1);
            e_busy = 1;
          end else begin
            e_cnt = 0; e_busy = 0;
          end
        end
      end
      if (sample_ENABLE) tick_no++;
      #1;
      chk("sample_counter", int'(sample_counter), e_cnt);
      chk("bit_index", int'(bit_index), m_bi);
      chk("sample_strobe", int'(sample_strobe), e_strobe);
      chk("busy", int'(busy), e_busy);
      chk("frame_done", int'(frame_done), e_fd);
      chk("start_error", int'(start_error), e_se);
      chk("stop_error", int'(stop_error), e_ste);
`ifdef UART_RX_PARITY_EN
      chk("parity_slot", int'(parity_w), e_par);
`endif
      if (sample_strobe) begin
        strobe_cnt++;
        if (prev_cnt != OS / 2) bad_mid++;
        if (parity_w) begin
          par_cnt++; par_at = strobe_cnt; par_rx = int'(rx_line);
        end else begin
          rx_bits[bit_index] = rx_line;
        end
      end
      if (frame_done)  begin fd_cnt++;  last_fd_tick  = tick_no; end
      if (start_error) begin se_cnt++;  last_se_tick  = tick_no; end
      if (stop_error)  begin ste_cnt++; last_ste_tick = tick_no; end
      prev_cnt = int'(sample_counter);
    end
  end

  int start_tick = 0;
  int s_strobe = 0, s_fd = 0, s_se = 0, s_ste = 0, s_par = 0, s_bad = 0;

  task automatic snap();
    s_strobe = strobe_cnt; s_fd = fd_cnt; s_se = se_cnt;
    s_ste = ste_cnt; s_par = par_cnt; s_bad = bad_mid;
  endtask

  // One sample tick spans 4 clocks; sample_ENABLE is high on the first.
  task automatic one_tick(input logic v, input bit drop);
    @(negedge clk); rx_line = v; sample_ENABLE = 1'b1;
    @(negedge clk); sample_ENABLE = 1'b0;
    if (drop) begin
      count_ENABLE = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_counter", int'(sample_counter), 0);
      @(negedge clk); count_ENABLE = 1'b1;
    end else begin
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n);
    repeat (n) one_tick(1'b1, 1'b0);
  endtask

  // Stop bit is driven only through its mid-point; the line then returns to idle.
  task automatic send_frame(input logic [15:0] data, input logic par, input logic stop, input int abort_at);
    int total, p;
    logic v;
    total = (LAST_PHASE + 1) * OS;
    start_tick = tick_no + 1;
    for (int k = 0; k < total; k++) begin
      p = k / OS;
      if (p == 0) v = 1'b0;
      else if (p <= DB) v = data[p-1];
      else if (p < LAST_PHASE) v = par;
      else v = (k % OS <= OS / 2) ? stop : 1'b1;
      one_tick(v, k == abort_at);
      if (k == abort_at) break;
    end
  endtask

  task automatic check_good_frame(input string tag, input logic [7:0] data, input logic par);
    chk({tag, "_strobes"}, strobe_cnt - s_strobe, DB + PE);
    chk({tag, "_data"}, int'(rx_bits[7:0]), int'(data));
    chk({tag, "_strobe_at_mid"}, bad_mid - s_bad, 0);
    chk({tag, "_frame_done"}, fd_cnt - s_fd, 1);
    chk({tag, "_fd_tick"}, last_fd_tick - start_tick, FD_TICK);
    chk({tag, "_stop_err"}, ste_cnt - s_ste, 0);
    chk({tag, "_start_err"}, se_cnt - s_se, 0);
    chk({tag, "_busy_after"}, int'(busy), 0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_parity_count"}, par_cnt - s_par, 1);
    chk({tag, "_parity_is_9th"}, par_at - s_strobe, 9);
    chk({tag, "_parity_rx"}, par_rx, int'(par));
`else
    if (par) begin end
`endif
  endtask

  initial begin
    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_counter", int'(sample_counter), 0);
    chk("rst_strobe", int'(sample_strobe), 0);
    reset = 1'b0;

    // 1: reset asserted mid-frame, then a long idle line.
    repeat (30) one_tick(1'b0, 1'b0);
    chk("pre_reset_busy", int'(busy), 1);
    chk("pre_reset_bit_index", int'(bit_index), 0);
    @(negedge clk); #2; reset = 1'b1; #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_counter", int'(sample_counter), 0);
    chk("async_rst_bit_index", int'(bit_index), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; rx_line = 1'b1;
    snap();
    idle_ticks(200);
    chk("idle_pulses", (strobe_cnt - s_strobe) + (fd_cnt - s_fd) + (se_cnt - s_se) + (ste_cnt - s_ste), 0);
    chk("idle_busy", int'(busy), 0);

    // 2: good frames.
    snap(); send_frame(16'h0055, 1'b0, 1'b1, -1); idle_ticks(4);
    check_good_frame("f55", 8'h55, 1'b0);
    snap(); send_frame(16'h00A3, 1'b0, 1'b1, -1); idle_ticks(4);
    check_good_frame("fA3", 8'hA3, 1'b0);

    // 3: false start.
    snap(); start_tick = tick_no + 1;
    repeat (3) one_tick(1'b0, 1'b0);
    idle_ticks(12);
    chk("fs_start_err", se_cnt - s_se, 1);
    chk("fs_tick", last_se_tick - start_tick, 8);
    chk("fs_strobes", strobe_cnt - s_strobe, 0);
    chk("fs_busy", int'(busy), 0);

    // 4: stop bit held low.
    snap(); send_frame(16'h00C3, 1'b1, 1'b0, -1); idle_ticks(4);
    chk("se_frame_done", fd_cnt - s_fd, 1);
    chk("se_stop_err", ste_cnt - s_ste, 1);
    chk("se_same_cycle", last_ste_tick - last_fd_tick, 0);
    chk("se_fd_tick", last_fd_tick - start_tick, FD_TICK);

    // 5: receiver disabled during data bit 3, then a clean frame.
    snap(); send_frame(16'h0096, 1'b1, 1'b1, 4 * OS + 4);
    idle_ticks(20);
    chk("ab_no_frame_done", fd_cnt - s_fd, 0);
    chk("ab_strobes", strobe_cnt - s_strobe, 3);
    chk("ab_busy", int'(busy), 0);
    snap(); send_frame(16'h0096, 1'b0, 1'b1, -1); idle_ticks(4);
    check_good_frame("f96", 8'h96, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_bit_timer.md
# uart_rx_bit_timer

Parametrised receive bit-timing engine for the UART receiver. It replaces the plain sample-enable counter with a framing state machine. It detects the start bit and validates it at mid-bit. It counts oversampling ticks per bit, issues one mid-bit sample strobe per data bit with its bit index, and reports frame completion, false starts and framing errors to the receive datapath. It sits between the baud/sample-enable generator and the receive shift register.

## Interface
Parameters:
- OVERSAMPLE, 16: sample_ENABLE pulses per bit period; must be even and ≥4.
- DATA_BITS, 8: data bits per frame; legal range 5–16.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- count_ENABLE  input  1  receiver enable; low forces IDLE synchronously.
- sample_ENABLE  input  1  one-clk pulse at OVERSAMPLE × baud rate.
- rx_line  input  1  serial input, already synchronised; idle high.
- sample_counter  output  $clog2(OVERSAMPLE)  tick index within current bit.
- bit_index  output  $clog2(DATA_BITS)  current data bit, LSB first.
- sample_strobe  output  1  one-clk pulse: the receiver samples rx_line for bit_index.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-clk pulse at the stop-bit mid-point.
- start_error  output  1  one-clk pulse on a false start bit.
- stop_error  output  1  one-clk pulse together with frame_done when the stop bit samples low.

## Operation
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - sample_counter = 0.
  - On sample_ENABLE with rx_line = 0, go to START with sample_counter = 1. The detecting tick is tick 0.
- Non-IDLE ticks, on each sample_ENABLE:
  - If sample_counter == OVERSAMPLE−1, set sample_counter = 0 and end the bit.
  - Otherwise increment sample_counter.
  - No other clock changes the counter.
- Mid-bit is defined as sample_ENABLE with sample_counter == OVERSAMPLE/2.
  - START at mid-bit: if rx_line = 1, pulse start_error and go to IDLE. Otherwise continue.
  - DATA at mid-bit: pulse sample_strobe.
  - STOP at mid-bit: pulse frame_done, plus stop_error if rx_line = 0. Go to IDLE at once so the next start edge can be detected in the second half of the stop bit.
- Bit end transitions:
  - START goes to DATA with bit_index = 0.
  - DATA increments bit_index.
  - After bit DATA_BITS−1, go to PARITY (macro defined) or STOP.
  - PARITY goes to STOP.
- count_ENABLE = 0 has priority over sample_ENABLE and rx_line. The next state is IDLE and all counters clear. Pulses in flight are suppressed.
- bit_index holds its last value outside DATA and is cleared on entering START.

## Timing
- Reset values: every output is 0; state is IDLE.
- All outputs are registered. Each pulse appears in the clk cycle after the qualifying sample_ENABLE edge and lasts exactly one clk.
- Valid frame without parity:
  - The first sample_strobe follows the tick OVERSAMPLE + OVERSAMPLE/2 after detection.
  - frame_done follows tick (DATA_BITS+1)·OVERSAMPLE + OVERSAMPLE/2 after detection.
- busy rises the cycle after the detecting tick and falls in the same cycle frame_done or start_error asserts.
- sample_counter wraps OVERSAMPLE−1 → 0 and never reaches OVERSAMPLE.
- Back-to-back sample_ENABLE on consecutive clocks is legal; every pulse counts.
- Reset asserted mid-frame clears everything immediately. No frame_done or error pulse is produced for the aborted frame.

## Configuration
- UART_RX_PARITY_EN defined:
  - A PARITY state is inserted between the last data bit and STOP.
  - Its mid-bit produces a sample_strobe with an extra output parity_slot = 1, which is 0 at all other times.
  - frame_done moves one bit period (OVERSAMPLE ticks) later.
- Undefined: no PARITY state and no parity_slot port.

## Test plan
All scenarios use OVERSAMPLE=16, DATA_BITS=8, and sample_ENABLE every 4 clk.
1. Reset during activity, then release -> all outputs 0, busy 0; idle-high rx_line produces no pulses for 200 ticks.
2. Frame 0x55 with a valid stop bit -> 8 sample_strobes at sample_counter 8 of each data bit, with bit_index 0..7 and rx_line at the strobes = 1,0,1,0,1,0,1,0. frame_done follows tick 152 after detection. No errors.
3. rx_line low for 3 ticks, then high -> start_error pulses after tick 8. No sample_strobe. busy returns to 0.
4. Frame with stop bit held low -> frame_done and stop_error pulse in the same cycle after tick 152.
5. count_ENABLE dropped during data bit 3 -> next cycle busy=0 and sample_counter=0. No frame_done. A new frame after re-enable decodes correctly.
6. With UART_RX_PARITY_EN defined -> 9 strobes, parity_slot high only on the 9th. frame_done follows tick 168.
